// File: rtl/restoring_divider.sv
// restoring_divider: unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_ZERO_DETECT_EN to short-circuit a zero divisor to DONE in one cycle with dbz_o set.
module restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] quotient_o,
    output logic [VW-1:0] remainder_o,
    output logic          dbz_o
);
    localparam int CW = $clog2(DW + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW:0]   prem_q, prem_d;
    logic [DW-1:0] dvd_q, dvd_d, quo_q, quo_d;
    logic [VW-1:0] dvs_q, dvs_d, rem_q, rem_d;
    logic [VW+1:0] shifted;
    logic          neg, accept, zskip, last;
    assign accept  = start_i && state_q != RUN;
`ifdef DIV_ZERO_DETECT_EN
    logic dbz_q, dbz_d;
    assign zskip = accept && divisor_i == '0;
    assign dbz_o = dbz_q;
`else
    assign zskip = 1'b0;
    assign dbz_o = 1'b0;
`endif
    assign last    = state_q == RUN && cnt_q == CW'(1);
    // the dividend register doubles as the quotient shift register
    assign shifted = {prem_q, dvd_q[DW-1]};
    assign neg     = shifted < {2'b0, dvs_q};
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (accept) state_d = zskip ? DONE : RUN;
        else if (state_q == DONE) state_d = IDLE;
        else if (last) state_d = DONE;
    end
    always_comb begin
        busy_o = state_q == RUN;
        done_o = state_q == DONE;
    end
    always_comb begin
        prem_d = prem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d  = dbz_q;
`endif
        if (accept) begin
            prem_d = '0;
            dvd_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = zskip ? '0 : CW'(DW);
            if (zskip) begin
                quo_d = '1;
                rem_d = dividend_i[VW-1:0];
`ifdef DIV_ZERO_DETECT_EN
                dbz_d = 1'b1;
`endif
            end
        end else if (state_q == RUN) begin
            prem_d = neg ? shifted[VW:0] : shifted[VW:0] - {1'b0, dvs_q};
            dvd_d  = {dvd_q[DW-2:0], ~neg};
            cnt_d  = cnt_q - CW'(1);
            if (last) begin
                quo_d = dvd_d;
                rem_d = prem_d[VW-1:0];
`ifdef DIV_ZERO_DETECT_EN
                dbz_d = 1'b0;
`endif
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prem_q <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q  <= 1'b0;
`endif
        end else begin
            prem_q <= prem_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q  <= dbz_d;
`endif
        end
    end
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and random divisions checked against an arithmetic reference.
module tb_restoring_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, dbz;
    logic [7:0] quotient;
    logic [3:0] remainder;
    int         passed = 0;
    int         total = 0;

    restoring_divider #(.DW(8), .VW(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .dividend_i(dividend),
        .divisor_i(divisor), .busy_o(busy), .done_o(done), .quotient_o(quotient),
        .remainder_o(remainder), .dbz_o(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_lat(input logic [3:0] b);
`ifdef DIV_ZERO_DETECT_EN
        return b == 0 ? 1 : 9;
`else
        return 9;
`endif
    endfunction

    function automatic logic exp_dbz(input logic [3:0] b);
`ifdef DIV_ZERO_DETECT_EN
        return b == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_done(output int lat, output logic clash);
        lat = 1;
        clash = 1'b0;
        while (!done && lat < 20) begin
            clash |= busy & done;
            @(posedge clk); #1;
            lat++;
        end
        clash |= busy & done;
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b);
        int   lat;
        logic clash;
        logic [7:0] eq;
        logic [3:0] er;
        eq = b == 0 ? 8'hFF : a / b;
        er = b == 0 ? a[3:0] : 4'(a % b);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy"}, busy, exp_lat(b) != 1);
        wait_done(lat, clash);
        check({tag, ".lat"}, lat, exp_lat(b));
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, dbz, exp_dbz(b));
        check({tag, ".excl"}, clash, 1'b0);
        @(posedge clk); #1;
        check({tag, ".pulse"}, done, 1'b0);
    endtask

    initial begin
        int   lat;
        int   seen;
        logic clash;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.dbz", dbz, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_div("9C/C", 8'h9C, 4'hC);
        check("9C/C.qconst", quotient, 8'h0D);
        run_div("C8/7", 8'hC8, 4'h7);
        check("C8/7.rconst", remainder, 4'h4);
        run_div("FF/1", 8'hFF, 4'h1);
        run_div("9C/0", 8'h9C, 4'h0);
        check("9C/0.rconst", remainder, 4'hC);
        run_div("00/5", 8'h00, 4'h5);
        run_div("0F/F", 8'h0F, 4'hF);

        start = 1'b1; dividend = 8'hA9; divisor = 4'hD;
        @(posedge clk); #1;
        dividend = 8'h6C; divisor = 4'hC;
        wait_done(lat, clash);
        check("b2b.lat1", lat, 9);
        check("b2b.q1", quotient, 8'h0D);
        check("b2b.r1", remainder, 4'h0);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.busy2", busy, 1);
        wait_done(lat, clash);
        check("b2b.gap", lat, 9);
        check("b2b.q2", quotient, 8'h09);
        check("b2b.r2", remainder, 4'h0);
        check("b2b.excl", clash, 0);
        @(posedge clk); #1;

        start = 1'b1; dividend = 8'hC8; divisor = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'h10; divisor = 4'h2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("ign.busy", busy, 1);
        check("ign.done", done, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid.busy", busy, 0);
        check("mid.done", done, 0);
        check("mid.q", quotient, 0);
        check("mid.r", remainder, 0);
        check("mid.dbz", dbz, 0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            seen += int'(done) + int'(busy);
        end
        check("mid.quiet", seen, 0);
        run_div("10/2", 8'h10, 4'h2);
        check("10/2.qconst", quotient, 8'h08);

        repeat (40) run_div("rand", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
